// File: rtl/decompress_in_framer_if.sv
// Byte-stream handshake bundle between the DMA read stream, the framer and the decoder.
// The framer takes the slave view; whoever feeds and drains it takes the master view.
interface decompress_in_framer_if #(
    parameter int unsigned AXIS_DW = 8
);
    logic [AXIS_DW-1:0] in_tdata;
    logic               in_tvalid;
    logic               in_tready;
    logic               in_tlast;
    logic [AXIS_DW-1:0] out_tdata;
    logic               out_tvalid;
    logic               out_tready;
    logic               out_tlast;

    modport master (
        output in_tdata,
        output in_tvalid,
        output in_tlast,
        output out_tready,
        input  in_tready,
        input  out_tdata,
        input  out_tvalid,
        input  out_tlast
    );

    modport slave (
        input  in_tdata,
        input  in_tvalid,
        input  in_tlast,
        input  out_tready,
        output in_tready,
        output out_tdata,
        output out_tvalid,
        output out_tlast
    );
endinterface

// File: rtl/decompress_in_framer.sv
// Input framer for the decompression path: strips block-boundary tlast, flags framing
// violations, counts blocks and forwards bytes through a one-deep output register.
module decompress_in_framer #(
    parameter int unsigned AXIS_DW        = 8,
    parameter int unsigned NumberPerBlock = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         FBFlag,
    decompress_in_framer_if.slave        bus,
    output logic [31:0]                  BlockCount,
    output logic                         FrameError,
    output logic                         FileFinish
);

    localparam int unsigned CntW = (NumberPerBlock > 1) ? $clog2(NumberPerBlock) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(NumberPerBlock - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    state_e             state_q;
    logic               mode_q;
    logic [CntW-1:0]    b_cnt_q;
    logic [31:0]        block_count_q;
    logic               frame_error_q;
    logic               file_finish_q;
    logic [AXIS_DW-1:0] out_data_q;
    logic               out_valid_q;
    logic               out_last_q;

    logic accept;
    logic at_wrap;
    logic file_end;
    logic handoff;

    always_comb begin
        bus.in_tready = (state_q == StRun) & (~out_valid_q | bus.out_tready);
        accept        = bus.in_tvalid & bus.in_tready;
        at_wrap       = (b_cnt_q == CntLast);
        // In block mode a tlast on the last byte of a block is only a boundary marker.
        file_end      = bus.in_tlast & (mode_q | ~at_wrap);
        handoff       = out_valid_q & bus.out_tready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            mode_q        <= 1'b0;
            b_cnt_q       <= '0;
            block_count_q <= '0;
            frame_error_q <= 1'b0;
            file_finish_q <= 1'b0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q       <= StRun;
                        mode_q        <= FBFlag;
                        b_cnt_q       <= '0;
                        block_count_q <= '0;
                        frame_error_q <= 1'b0;
                        file_finish_q <= 1'b0;
                    end
                end
                StRun: begin
                    if (accept && file_end) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (handoff && out_last_q) begin
                        state_q       <= StDone;
                        file_finish_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (accept) begin
                out_data_q  <= bus.in_tdata;
                out_valid_q <= 1'b1;
                out_last_q  <= file_end;
                // Coincident tlast and wrap close a single block.
                if (bus.in_tlast || at_wrap) begin
                    b_cnt_q <= '0;
                    if (block_count_q != 32'hFFFF_FFFF) begin
                        block_count_q <= block_count_q + 32'd1;
                    end
                end else begin
                    b_cnt_q <= b_cnt_q + CntW'(1);
                end
                if (!mode_q && at_wrap && !bus.in_tlast) begin
                    frame_error_q <= 1'b1;
                end
            end else if (handoff) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    assign bus.out_tdata  = out_data_q;
    assign bus.out_tvalid = out_valid_q;
    assign bus.out_tlast  = out_last_q;
    assign BlockCount     = block_count_q;
    assign FrameError     = frame_error_q;
    assign FileFinish     = file_finish_q;

endmodule
